// File: rtl/elastic_pipe_register.sv
// Multi-stage valid/ready pipeline register: DEPTH stages of WIDTH-bit words,
// bubble collapsing under back-pressure, synchronous reset and flush.
module elastic_pipe_register #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 2,
    parameter bit CLR_DATA = 1'b1,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    logic [DEPTH-1:0] v_reg;
    logic [WIDTH-1:0] d_reg [DEPTH];
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] src_v;
    logic [WIDTH-1:0] src_d [DEPTH];
    logic [CW-1:0]    count_reg;
    logic             in_hs;
    logic             out_hs;

    assign in_ready  = adv[0] & ~flush;
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = v_reg[DEPTH-1] & out_ready;
    assign out_valid = v_reg[DEPTH-1];
    assign out_data  = d_reg[DEPTH-1];
    assign count     = count_reg;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            // A stage can move only if some stage at or beyond it is empty, or the consumer pops.
            // Written as a reduction over the valid bits so the ready path has no combinational loop.
            assign adv[gi] = out_ready | ~(&v_reg[DEPTH-1:gi]);
            if (gi == 0) begin : g_head
                assign src_v[gi] = in_hs;
                assign src_d[gi] = in_data;
            end else begin : g_body
                assign src_v[gi] = v_reg[gi-1];
                assign src_d[gi] = d_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            v_reg <= '0;
            if (CLR_DATA) begin
                for (int i = 0; i < DEPTH; i++) begin
                    d_reg[i] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (adv[i]) begin
                    v_reg[i] <= src_v[i];
                    // Data only moves with a valid word; bubbles leave it untouched.
                    if (src_v[i]) begin
                        d_reg[i] <= src_d[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CW'(in_hs) - CW'(out_hs);
        end
    end

endmodule

// File: tb/tb_elastic_pipe_register.sv
// Directed and randomised checks of elastic_pipe_register: DEPTH=3 directed
// sequence, then randomised scoreboard runs on DEPTH=1 and DEPTH=4 instances.
module tb_elastic_pipe_register;

    logic       clk;
    logic       rst, flush, in_valid, out_ready;
    logic [7:0] in_data;
    logic       in_ready, out_valid;
    logic [7:0] out_data;
    logic [1:0] count;

    // randomised instances: index 0 -> DEPTH=1, index 1 -> DEPTH=4
    logic       rrst;
    logic       r_iv [2];
    logic       r_or [2];
    logic [7:0] r_id [2];
    logic       r_ir [2];
    logic       r_ov [2];
    logic [7:0] r_od [2];
    logic [2:0] r_cnt [2];
    logic       cnt_a;
    logic [2:0] cnt_b;

    int tests = 0;
    int fails = 0;

    elastic_pipe_register #(.WIDTH(8), .DEPTH(3), .CLR_DATA(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    elastic_pipe_register #(.WIDTH(8), .DEPTH(1), .CLR_DATA(1'b1)) dut_a (
        .clk(clk), .rst(rrst), .flush(1'b0),
        .in_valid(r_iv[0]), .in_ready(r_ir[0]), .in_data(r_id[0]),
        .out_valid(r_ov[0]), .out_ready(r_or[0]), .out_data(r_od[0]),
        .count(cnt_a)
    );

    elastic_pipe_register #(.WIDTH(8), .DEPTH(4), .CLR_DATA(1'b0)) dut_b (
        .clk(clk), .rst(rrst), .flush(1'b0),
        .in_valid(r_iv[1]), .in_ready(r_ir[1]), .in_data(r_id[1]),
        .out_valid(r_ov[1]), .out_ready(r_or[1]), .out_data(r_od[1]),
        .count(cnt_b)
    );

    assign r_cnt[0] = {2'b00, cnt_a};
    assign r_cnt[1] = cnt_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one edge and let registered outputs settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] mem [2][8];
    int         head [2];
    int         tail [2];
    logic       stall_prev [2];
    logic [7:0] data_prev [2];

    initial begin
        int sz;
        int dp;
        logic exp_ir;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        rrst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            r_iv[k] = 1'b0; r_or[k] = 1'b0; r_id[k] = 8'h00;
            head[k] = 0; tail[k] = 0; stall_prev[k] = 1'b0; data_prev[k] = 8'h00;
        end

        // T1: reset
        tick(); tick();
        chk("t1_out_valid", out_valid, 0);
        chk("t1_out_data", out_data, 8'h00);
        chk("t1_count", count, 0);
        rst = 1'b0; rrst = 1'b0;
        #1;
        chk("t1_in_ready", in_ready, 1);

        // T2: streaming with latency DEPTH-1 after acceptance
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h11; tick();
        chk("t2_ov_e1", out_valid, 0);
        in_data = 8'h22; tick();
        chk("t2_ov_e2", out_valid, 0);
        chk("t2_cnt_e2", count, 2);
        in_data = 8'h33; tick();
        in_valid = 1'b0;
        chk("t2_ov_e3", out_valid, 1);
        chk("t2_d_e3", out_data, 8'h11);
        chk("t2_cnt_e3", count, 3);
        tick();
        chk("t2_d_e4", out_data, 8'h22);
        chk("t2_cnt_e4", count, 2);
        tick();
        chk("t2_d_e5", out_data, 8'h33);
        tick();
        chk("t2_ov_e6", out_valid, 0);
        chk("t2_cnt_e6", count, 0);

        // T3: fill under back-pressure, then simultaneous pop and push when full
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hA0; tick();
        in_data = 8'hA1; tick();
        in_data = 8'hA2; tick();
        in_data = 8'hA3;
        #1;
        chk("t3_in_ready_full", in_ready, 0);
        chk("t3_cnt_full", count, 3);
        chk("t3_d_head", out_data, 8'hA0);
        tick();
        chk("t3_cnt_hold", count, 3);
        chk("t3_d_hold", out_data, 8'hA0);
        out_ready = 1'b1;
        #1;
        chk("t3_in_ready_pop", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("t3_cnt_swap", count, 3);
        chk("t3_d_a1", out_data, 8'hA1);
        tick();
        chk("t3_d_a2", out_data, 8'hA2);
        tick();
        chk("t3_d_a3", out_data, 8'hA3);
        tick();
        chk("t3_ov_empty", out_valid, 0);
        chk("t3_cnt_empty", count, 0);

        // T4: flush with two words held and a word offered
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h01; tick();
        in_data = 8'h02; tick();
        chk("t4_cnt_pre", count, 2);
        flush = 1'b1; in_data = 8'h5A;
        #1;
        chk("t4_in_ready_flush", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("t4_cnt_post", count, 0);
        chk("t4_ov_post", out_valid, 0);
        chk("t4_d_post", out_data, 8'h00);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_no_5a", out_valid, 0);
        end

        // T5: reset mid-stream while full and stalled
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hB0; tick();
        in_data = 8'hB1; tick();
        in_data = 8'hB2; tick();
        chk("t5_cnt_pre", count, 3);
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_cnt_rst", count, 0);
        chk("t5_ov_rst", out_valid, 0);
        chk("t5_d_rst", out_data, 8'h00);
        in_valid = 1'b1; in_data = 8'hC3; tick();
        in_valid = 1'b0; out_ready = 1'b1;
        chk("t5_ov_f1", out_valid, 0);
        tick();
        chk("t5_ov_f2", out_valid, 0);
        tick();
        chk("t5_ov_f3", out_valid, 1);
        chk("t5_d_f3", out_data, 8'hC3);
        chk("t5_cnt_f3", count, 1);
        tick();
        chk("t5_cnt_f4", count, 0);

        // T6: random traffic on DEPTH=1 and DEPTH=4 against a FIFO scoreboard
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                r_iv[k] = 1'($urandom_range(0, 1));
                r_or[k] = 1'($urandom_range(0, 1));
                r_id[k] = 8'($urandom_range(0, 255));
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                sz = tail[k] - head[k];
                dp = (k == 0) ? 1 : 4;
                exp_ir = !(sz == dp && !r_or[k]);
                chk("rnd_in_ready", r_ir[k], exp_ir);
                chk("rnd_count", r_cnt[k], sz);
                if (sz == 0) begin
                    chk("rnd_ov_empty", r_ov[k], 0);
                end else if (r_ov[k]) begin
                    chk("rnd_order", r_od[k], mem[k][head[k] % 8]);
                end
                if (stall_prev[k]) begin
                    chk("rnd_stall_valid", r_ov[k], 1);
                    chk("rnd_stall_data", r_od[k], data_prev[k]);
                end
                if (r_iv[k] && exp_ir) begin
                    mem[k][tail[k] % 8] = r_id[k];
                    tail[k]++;
                end
                if (r_ov[k] && r_or[k] && sz > 0) begin
                    head[k]++;
                end
                stall_prev[k] = r_ov[k] && !r_or[k];
                data_prev[k]  = r_od[k];
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
